// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Packs symbolic LEGv8 instructions into 32-bit machine words
//                and streams them into instruction memory with an
//                auto-incrementing address. Out-of-range immediates and
//                illegal op classes are consumed but never written.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [31:0]       imm,
    input  logic [1:0]        hw,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              err,
    output logic              done,
    output logic [ADDR_W:0]   length
);

    localparam logic [ADDR_W+1:0] DEPTH_C = (ADDR_W+2)'(DEPTH);

    localparam logic [3:0] OP_B     = 4'd0;
    localparam logic [3:0] OP_BLT   = 4'd1;
    localparam logic [3:0] OP_CBZ   = 4'd2;
    localparam logic [3:0] OP_ADDS  = 4'd3;
    localparam logic [3:0] OP_SUBS  = 4'd4;
    localparam logic [3:0] OP_ADDI  = 4'd5;
    localparam logic [3:0] OP_STURB = 4'd6;
    localparam logic [3:0] OP_LDURB = 4'd7;
    localparam logic [3:0] OP_STUR  = 4'd8;
    localparam logic [3:0] OP_LDUR  = 4'd9;
    localparam logic [3:0] OP_MOVZ  = 4'd10;
    localparam logic [3:0] OP_MOVK  = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] word;
    logic        legal;
    logic        xfer;
    logic        s26_ok;
    logic        s19_ok;
    logic        s9_ok;
    logic        u12_ok;
    logic        u16_ok;
    logic [ADDR_W+1:0] occupancy;
    logic [ADDR_W+1:0] length_inc;

    // A signed N-bit value has all bits above N-2 equal to its sign bit.
    assign s26_ok = (&imm[31:25]) | ~(|imm[31:25]);
    assign s19_ok = (&imm[31:18]) | ~(|imm[31:18]);
    assign s9_ok  = (&imm[31:8])  | ~(|imm[31:8]);
    assign u12_ok = ~(|imm[31:12]);
    assign u16_ok = ~(|imm[31:16]);

    // Words already written plus the one being strobed this cycle.
    assign occupancy  = {1'b0, length} + {{(ADDR_W+1){1'b0}}, im_we};
    assign length_inc = {1'b0, length} + (ADDR_W+2)'(1);

    assign in_ready = (state == LOAD) && (occupancy < DEPTH_C);

    // start pre-empts any handshake offered in the same cycle.
    assign xfer = in_valid && in_ready && !start;

    // Field packing and immediate range check for the presented instruction.
    always_comb begin
        word  = 32'd0;
        legal = 1'b0;
        case (op)
            OP_B: begin
                word  = {6'b000101, imm[25:0]};
                legal = s26_ok;
            end
            OP_BLT: begin
                word  = {8'b01010100, imm[18:0], 5'b01011};
                legal = s19_ok;
            end
            OP_CBZ: begin
                word  = {8'b10110100, imm[18:0], rd};
                legal = s19_ok;
            end
            OP_ADDS: begin
                word  = {11'b10101011000, rm, 6'b000000, rn, rd};
                legal = 1'b1;
            end
            OP_SUBS: begin
                word  = {11'b11101011000, rm, 6'b000000, rn, rd};
                legal = 1'b1;
            end
            OP_ADDI: begin
                word  = {10'b1001000100, imm[11:0], rn, rd};
                legal = u12_ok;
            end
            OP_STURB: begin
                word  = {11'b00111000000, imm[8:0], 2'b00, rn, rd};
                legal = s9_ok;
            end
            OP_LDURB: begin
                word  = {11'b00111000010, imm[8:0], 2'b00, rn, rd};
                legal = s9_ok;
            end
            OP_STUR: begin
                word  = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
                legal = s9_ok;
            end
            OP_LDUR: begin
                word  = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
                legal = s9_ok;
            end
            OP_MOVZ: begin
                word  = {9'b110100101, hw, imm[15:0], rd};
                legal = u16_ok;
            end
            OP_MOVK: begin
                word  = {9'b111100101, hw, imm[15:0], rd};
                legal = u16_ok;
            end
            default: begin
                word  = 32'd0;
                legal = 1'b0;
            end
        endcase
    end

    // Program sequencer: state, write strobe, pointer/length and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
            err      <= 1'b0;
            done     <= 1'b0;
            length   <= '0;
        end else begin
            im_we <= 1'b0;
            err   <= 1'b0;
            if (start) begin
                state   <= LOAD;
                im_addr <= '0;
                length  <= '0;
                done    <= 1'b0;
            end else begin
                // The strobed word is committed at the end of its cycle,
                // even if the program is being closed meanwhile.
                if (im_we) begin
                    im_addr <= im_addr + ADDR_W'(1);
                    length  <= length + (ADDR_W+1)'(1);
                end
                if (xfer) begin
                    if (legal) begin
                        im_we    <= 1'b1;
                        im_wdata <= word;
                    end else begin
                        err <= 1'b1;
                    end
                end
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    LOAD: begin
                        if (finish) begin
                            state <= DONE;
                            // A write launched on this edge must land first.
                            done  <= !(xfer && legal);
                        end else if (im_we && (length_inc == DEPTH_C)) begin
                            state <= FULL;
                        end
                    end
                    FULL: begin
                        if (finish) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        done <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder_loader
//  Description : Self-checking bench for instr_encoder_loader (DEPTH=4 build)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              finish = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        op = '0;
    logic [4:0]        rd = '0;
    logic [4:0]        rn = '0;
    logic [4:0]        rm = '0;
    logic [31:0]       imm = '0;
    logic [1:0]        hw = '0;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              err;
    logic              done;
    logic [ADDR_W:0]   length;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd), .rn(rn),
        .rm(rm), .imm(imm), .hw(hw), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .err(err), .done(done), .length(length)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: program mode (0 none, 1 loading, 2 closed), words
    // committed, and the output slot expected after the next edge.
    int          m_mode;
    int          m_len;
    bit          m_we;
    bit          m_err;
    bit          m_done;
    logic [31:0] m_wdata;

    logic [31:0] bnd [15] = '{32'd4095, 32'd4096, 32'd65535, 32'd65536,
                              32'd255, 32'hFFFF_FF00, 32'd256, 32'hFFFF_FEFF,
                              32'h0003_FFFF, 32'hFFFC_0000, 32'h0004_0000,
                              32'h01FF_FFFF, 32'hFE00_0000, 32'h0200_0000,
                              32'hFDFF_FFFF};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        return (m_mode == 1) && ((m_len + int'(m_we)) < DEPTH);
    endfunction

    // Instruction word built arithmetically from opcode bases and shifted fields.
    function automatic void ref_encode(input int o, input logic [4:0] d, n, m,
                                       input logic [31:0] i, input logic [1:0] h,
                                       output bit ok, output logic [31:0] w);
        longint s;
        s  = longint'($signed(i));
        ok = 1'b0;
        w  = 32'd0;
        case (o)
            0: begin ok = (s >= -(64'sd1 << 25)) && (s < (64'sd1 << 25));
                     w = 32'h1400_0000 + (i & 32'h03FF_FFFF); end
            1: begin ok = (s >= -(64'sd1 << 18)) && (s < (64'sd1 << 18));
                     w = 32'h5400_0000 + ((i & 32'h7FFFF) << 5) + 32'd11; end
            2: begin ok = (s >= -(64'sd1 << 18)) && (s < (64'sd1 << 18));
                     w = 32'hB400_0000 + ((i & 32'h7FFFF) << 5) + 32'(d); end
            3, 4: begin ok = 1'b1;
                     w = ((o == 3) ? 32'hAB00_0000 : 32'hEB00_0000)
                         + (32'(m) << 16) + (32'(n) << 5) + 32'(d); end
            5: begin ok = (i < 32'd4096);
                     w = 32'h9100_0000 + ((i & 32'hFFF) << 10) + (32'(n) << 5) + 32'(d); end
            6, 7, 8, 9: begin
                     ok = (s >= -256) && (s <= 255);
                     w = (o == 6) ? 32'h3800_0000 : (o == 7) ? 32'h3840_0000 :
                         (o == 8) ? 32'hF800_0000 : 32'hF840_0000;
                     w = w + ((i & 32'h1FF) << 12) + (32'(n) << 5) + 32'(d); end
            10, 11: begin ok = (i < 32'd65536);
                     w = ((o == 10) ? 32'hD280_0000 : 32'hF280_0000)
                         + (32'(h) << 21) + ((i & 32'hFFFF) << 5) + 32'(d); end
            default: begin ok = 1'b0; w = 32'd0; end
        endcase
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_len = 0; m_we = 0; m_err = 0; m_done = 0; m_wdata = 32'd0;
    endfunction

    function automatic void model_edge();
        bit          x;
        bit          ok;
        logic [31:0] w;
        ref_encode(int'(op), rd, rn, rm, imm, hw, ok, w);
        x = in_valid && exp_ready();
        if (start) begin
            m_mode = 1; m_len = 0; m_done = 0; m_we = 0; m_err = 0;
        end else begin
            if (m_we) m_len++;
            if (m_mode == 1 && finish) begin
                m_mode = 2;
                m_done = !(x && ok);
            end else if (m_mode == 2) begin
                m_done = 1;
            end
            m_we  = x && ok;
            m_err = x && !ok;
            if (x && ok) m_wdata = w;
        end
    endfunction

    task automatic compare_all(input string ph);
        chk({ph, ".in_ready"}, 64'(in_ready), 64'(exp_ready()));
        chk({ph, ".im_we"},    64'(im_we),    64'(m_we));
        chk({ph, ".im_addr"},  64'(im_addr),  64'(m_len % (1 << ADDR_W)));
        chk({ph, ".im_wdata"}, 64'(im_wdata), 64'(m_wdata));
        chk({ph, ".err"},      64'(err),      64'(m_err));
        chk({ph, ".done"},     64'(done),     64'(m_done));
        chk({ph, ".length"},   64'(length),   64'(m_len));
    endtask

    // One clock: drive at the falling edge, predict, sample 1 time unit after the rise.
    task automatic step(input string ph, input bit s, f, v, input logic [3:0] o,
                        input logic [4:0] d, n, m, input logic [31:0] i,
                        input logic [1:0] h);
        @(negedge clk);
        start = s; finish = f; in_valid = v; op = o; rd = d; rn = n; rm = m;
        imm = i; hw = h;
        model_edge();
        @(posedge clk);
        #1;
        compare_all(ph);
    endtask

    task automatic idle(input string ph);
        step(ph, 0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0);
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return 32'($urandom_range(0, 511)) - 32'd256;
            2: return bnd[$urandom_range(0, 14)];
            3: return 32'($urandom_range(0, 70000));
            default: return 32'($urandom_range(0, 1 << 20)) - 32'h0008_0000;
        endcase
    endfunction

    initial begin
        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        idle("idle");
        step("valid_in_idle", 0, 0, 1, 4'd3, 5'd3, 5'd1, 5'd2, 32'd0, 2'd0);

        // First program: single ADDS
        step("start1", 1, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0);
        step("adds", 0, 0, 1, 4'd3, 5'd3, 5'd1, 5'd2, 32'd0, 2'd0);
        chk("adds_we", 64'(im_we), 64'd1);
        chk("adds_addr", 64'(im_addr), 64'd0);
        chk("adds_word", 64'(im_wdata), 64'hAB02_0023);
        idle("adds_after");
        chk("adds_len", 64'(length), 64'd1);
        step("finish1", 0, 1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0);

        // Second program: back-to-back, range checks, fill to DEPTH
        step("start2", 1, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0);
        step("addi", 0, 0, 1, 4'd5, 5'd0, 5'd31, 5'd0, 32'd5, 2'd0);
        chk("addi_word", 64'(im_wdata), 64'h9100_17E0);
        chk("addi_addr", 64'(im_addr), 64'd0);
        step("b", 0, 0, 1, 4'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 2'd0);
        chk("b_word", 64'(im_wdata), 64'h17FF_FFFF);
        chk("b_addr", 64'(im_addr), 64'd1);
        step("cbz", 0, 0, 1, 4'd2, 5'd4, 5'd0, 5'd0, 32'd2, 2'd0);
        chk("cbz_word", 64'(im_wdata), 64'hB400_0044);
        chk("cbz_addr", 64'(im_addr), 64'd2);
        chk("cbz_we", 64'(im_we), 64'd1);
        step("addi_big", 0, 0, 1, 4'd5, 5'd1, 5'd1, 5'd0, 32'd4096, 2'd0);
        chk("addi_big_err", 64'(err), 64'd1);
        chk("addi_big_we", 64'(im_we), 64'd0);
        step("op13", 0, 0, 1, 4'd13, 5'd1, 5'd1, 5'd1, 32'd0, 2'd0);
        chk("op13_err", 64'(err), 64'd1);
        chk("op13_len", 64'(length), 64'd3);
        step("ldur", 0, 0, 1, 4'd9, 5'd2, 5'd5, 5'd0, 32'hFFFF_FF00, 2'd0);
        chk("ldur_word", 64'(im_wdata), 64'hF850_00A2);
        chk("ldur_addr", 64'(im_addr), 64'd3);
        chk("ldur_ready", 64'(in_ready), 64'd0);
        step("fifth", 0, 0, 1, 4'd3, 5'd1, 5'd1, 5'd1, 32'd0, 2'd0);
        chk("fifth_we", 64'(im_we), 64'd0);
        chk("full_len", 64'(length), 64'd4);
        step("finish2", 0, 1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0);
        chk("finish2_done", 64'(done), 64'd1);
        chk("finish2_len", 64'(length), 64'd4);

        // start with a simultaneous offer while DONE
        step("restart", 1, 0, 1, 4'd3, 5'd7, 5'd6, 5'd5, 32'd0, 2'd0);
        chk("restart_we", 64'(im_we), 64'd0);
        chk("restart_len", 64'(length), 64'd0);
        chk("restart_done", 64'(done), 64'd0);
        step("post_restart", 0, 0, 1, 4'd3, 5'd7, 5'd6, 5'd5, 32'd0, 2'd0);
        chk("post_restart_addr", 64'(im_addr), 64'd0);
        chk("post_restart_we", 64'(im_we), 64'd1);
        step("stream", 0, 0, 1, 4'd4, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0);

        // Asynchronous reset while a strobe is live
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_reset");
        chk("async_reset_we", 64'(im_we), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        in_valid = 1'b0;
        idle("after_reset");
        chk("after_reset_ready", 64'(in_ready), 64'd0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            bit s;
            bit f;
            s = (m_mode != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            f = ($urandom_range(0, 24) == 0);
            step("rand", s, f, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 5'($urandom), 5'($urandom), 5'($urandom), rand_imm(), 2'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the LEGv8 instruction decoder: accepts one symbolic instruction per handshake (op class, register numbers, immediate) and packs it into the 32-bit machine word the decoder consumes.
- Writes each word sequentially into instruction memory through a one-cycle write strobe with an auto-incrementing address.
- Used by the bench/boot path to load programs before the CPU leaves reset.
- Range-checks immediates. Rejected instructions are never written.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, maximum words per program; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a new program at address 0
- finish  in  1  one-cycle pulse; close the program
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept this cycle
- op  in  4  0 B, 1 B.LT, 2 CBZ, 3 ADDS, 4 SUBS, 5 ADDI, 6 STURB, 7 LDURB, 8 STUR, 9 LDUR, 10 MOVZ, 11 MOVK; 12-15 illegal
- rd  in  5  Rd/Rt
- rn  in  5  Rn
- rm  in  5  Rm
- imm  in  32  immediate, two's complement
- hw  in  2  MOVZ/MOVK shift field
- im_we  out  1  instruction-memory write strobe
- im_addr  out  ADDR_W  write address
- im_wdata  out  32  encoded word
- err  out  1  one-cycle pulse; accepted instruction rejected
- done  out  1  program closed, level
- length  out  ADDR_W+1  words written in current program

Behaviour:
- Reset values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, err=0, done=0, length=0. FSM enters IDLE.
- FSM states are IDLE, LOAD, FULL, DONE.
  - IDLE to LOAD on start.
  - LOAD to FULL when length reaches DEPTH.
  - LOAD or FULL to DONE on finish.
  - DONE to LOAD on start.
- start in any state clears the write pointer and length to 0, drops done, and enters LOAD. start wins over finish and over a same-cycle handshake; that handshake is not accepted.
- in_ready = (state==LOAD) && (length + pending write < DEPTH). It is combinational from registered state only.
- A transfer occurs on a rising edge with in_valid && in_ready.
- Latency:
  - The word is encoded combinationally and registered at the transfer edge.
  - im_we is high for exactly the following cycle, with im_addr = write pointer and im_wdata = word.
  - The pointer and length increment at the end of that cycle.
- Back-to-back transfers give continuous im_we with consecutive addresses.
- Encodings (bit fields MSB first):
  - B: 000101 | imm[25:0].
  - B.LT: 01010100 | imm[18:0] | 01011.
  - CBZ: 10110100 | imm[18:0] | rd.
  - ADDS: 10101011000 | rm | 000000 | rn | rd.
  - SUBS: 11101011000 | rm | 000000 | rn | rd.
  - ADDI: 1001000100 | imm[11:0] | rn | rd.
  - STURB, LDURB, STUR, LDUR: opcodes 00111000000, 00111000010, 11111000000, 11111000010 | imm[8:0] | 00 | rn | rd.
  - MOVZ: 110100101 | hw | imm[15:0] | rd.
  - MOVK: 111100101 | hw | imm[15:0] | rd.
- Range rules:
  - B: imm must be a 26-bit signed value; bits 31:25 are all equal.
  - B.LT and CBZ: 19-bit signed.
  - D-type: 9-bit signed.
  - ADDI: unsigned, 0..4095.
  - MOVZ/MOVK: unsigned, 0..65535.
  - R-type ignores imm.
- Illegal op or out-of-range imm: the instruction is consumed (handshake completes), err pulses in the im_we slot, im_we stays 0, and the pointer and length are unchanged.
- finish with a write pending: that write completes, then done=1. length is frozen while DONE.
- in_valid outside LOAD: ignored, no err.
- Asynchronous reset mid-program: all state clears immediately and no partial write strobe is produced.

Test Plan:
- Reset, start, then ADDS rd=3 rn=1 rm=2: the following cycle im_we=1, im_addr=0, im_wdata=0xAB020023; length becomes 1.
- Back-to-back, in_valid held: ADDI rd=0 rn=31 imm=5 → 0x910017E0; B imm=-1 → 0x17FFFFFF; CBZ rd=4 imm=2 → 0xB4000044. Expect three consecutive strobes at addresses 0, 1, 2.
- Range checks:
  - ADDI imm=4096 → err pulse, no im_we, length unchanged.
  - op=13 → err pulse, no im_we, length unchanged.
  - LDUR rd=2 rn=5 imm=-256 → 0xF85000A2 written.
- DEPTH=4 build, 5 instructions offered: 4 writes, in_ready drops after the 4th transfer, state is FULL, and the 5th is not accepted. finish → done=1, length=4.
- start asserted together with in_valid in DONE: no write that cycle, length=0, done=0. The next transfer writes address 0.
- reset_n low while im_we=1 mid-stream: all outputs go to 0 asynchronously. After release, the block sits in IDLE with in_ready=0.
